store_datagen: RTL and testbench
================================

// Module: store_datagen
// PURPOSE
//   Store-side counterpart of the load write-data path: takes S-type stores (SB/SH/SW)
//   from the execute stage, replicates rs2 data into lanes and builds byte write enables
//   from daddr[1:0]. Holds accepted stores in a small store buffer and drains them to dmem.
//   Sits between the ALU/regfile and the data-memory write port.
// PARAMETERS
//   DEPTH  2   store-buffer entries; power of two, >= 2
// PORTS
//   clk          in   1   single clock, rising edge
//   reset        in   1   asynchronous, active-high
//   st_valid     in   1   store request valid
//   st_ready     out  1   buffer can accept a request this cycle
//   st_size      in   3   Instruction[14:12]: 000 SB, 001 SH, 010 SW
//   st_addr      in   32  byte address (ALU result)
//   st_data      in   32  rs2 value, data right-justified
//   st_misalign  out  1   one-cycle pulse: the accepted store was misaligned or had an illegal size
//   dvalid       out  1   head entry presented to dmem
//   dready       in   1   dmem takes the head entry this cycle
//   daddr        out  32  word address of head, daddr[1:0] = 2'b00
//   dwe          out  4   byte write enables of head, dwe[i] enables dwdata[8i+7:8i]
//   dwdata       out  32  lane-replicated write data of head
//   ld_addr      in   32  address of the load in the same stage
//   ld_hazard    out  1   buffered store overlaps ld_addr's word
//   sb_empty     out  1   buffer holds no entries
// BEHAVIOUR
//   Clock and reset:
//   - Reset (async assert, sync release): rd/wr pointers and count = 0; dvalid = 0,
//     dwe = 0, daddr = 0, dwdata = 0, st_misalign = 0, sb_empty = 1.
//   - Reset mid-operation discards all buffered stores; nothing is written to dmem afterwards.
//   Accept:
//   - st_ready = (count < DEPTH). A store is accepted when st_valid && st_ready.
//   - No push when full, even if a pop happens in the same cycle.
//   Encoding (accepted, legal store):
//   - SB: dwe = 4'b0001 << addr[1:0]; dwdata = {4{st_data[7:0]}}.
//   - SH: dwe = addr[1] ? 4'b1100 : 4'b0011; dwdata = {2{st_data[15:0]}}.
//   - SW: dwe = 4'b1111; dwdata = st_data.
//   - Entry stores {addr[31:2], 2'b00, dwe, dwdata}.
//   Illegal stores:
//   - Misaligned means SH with addr[0] = 1, or SW with addr[1:0] != 0.
//   - Illegal size means st_size is not 000, 001 or 010.
//   - Either case: the request is still accepted (handshake completes), but it is not
//     enqueued. st_misalign = 1 in the following cycle only.
//   Drain:
//   - dvalid = !empty. daddr, dwe and dwdata come from the head entry, driven from registers.
//   - dwe = 0 whenever dvalid = 0.
//   - Pop on dvalid && dready; the next entry is visible the following cycle.
//   - Head fields are held stable while dvalid && !dready.
//   - Minimum latency: accept in cycle N -> dvalid in cycle N+1 (empty buffer).
//   Count and ordering:
//   - Simultaneous push and pop (non-full buffer): count is unchanged, order is preserved (FIFO).
//   - Pointers wrap modulo DEPTH.
//   Load hazard:
//   - ld_hazard (combinational) = 1 if any valid entry has entry.daddr[31:2] == ld_addr[31:2].
//   - Empty buffer -> ld_hazard = 0.
// TESTING
//   - SB addr=0x103, data=0xAB, dready=1 -> next cycle dvalid=1, daddr=0x100, dwe=1000, dwdata=0xABABABAB; popped.
//   - SH addr=0x202, data=0x1234; SW addr=0x300, data=0xDEADBEEF
//       -> dwe=1100, dwdata=0x12341234; then dwe=1111, dwdata=0xDEADBEEF.
//   - dready=0, push 2 stores -> st_ready=0 on the third request;
//       raise dready -> drained in order, sb_empty=1 after the second pop.
//   - SW addr=0x401 -> st_misalign pulses 1 cycle, dvalid stays 0;
//       st_size=011 -> same response.
//   - Buffer holds SW 0x500, ld_addr=0x503 -> ld_hazard=1; ld_addr=0x504 -> ld_hazard=0.
//   - Assert reset while 2 entries are buffered and dready=0
//       -> immediately dvalid=0, dwe=0, sb_empty=1; no dmem write after release.

Source files
------------

// File: rtl/store_datagen_if.sv
// store_datagen_if: store request, dmem write port and load-hazard signals of the store data path.
interface store_datagen_if;
    logic        st_valid;
    logic        st_ready;
    logic [2:0]  st_size;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic        st_misalign;
    logic        dvalid;
    logic        dready;
    logic [31:0] daddr;
    logic [3:0]  dwe;
    logic [31:0] dwdata;
    logic [31:0] ld_addr;
    logic        ld_hazard;
    logic        sb_empty;
    modport slave (
        input  st_valid, st_size, st_addr, st_data, dready, ld_addr,
        output st_ready, st_misalign, dvalid, daddr, dwe, dwdata, ld_hazard, sb_empty
    );
    modport master (
        output st_valid, st_size, st_addr, st_data, dready, ld_addr,
        input  st_ready, st_misalign, dvalid, daddr, dwe, dwdata, ld_hazard, sb_empty
    );
endinterface

// File: rtl/store_datagen.sv
// store_datagen: encodes SB/SH/SW stores into lane data and byte enables and buffers them for dmem.
module store_datagen #(
    parameter int DEPTH = 2
) (
    input logic            clk_i,
    input logic            reset_i,
    store_datagen_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    logic [29:0]      addr_q [DEPTH];
    logic [3:0]       we_q [DEPTH];
    logic [31:0]      data_q [DEPTH];
    logic [DEPTH-1:0] vld_q;
    logic [PW-1:0]    rd_q, wr_q;
    logic             mis_q;
    logic [3:0]       we_d;
    logic [31:0]      data_d;
    logic             bad, accept, push, pop, empty, haz;
    logic             unused_ok;
    assign unused_ok = ^bus.ld_addr[1:0];
    // Per-slot valid bits: the slot at wr_q is occupied only when the buffer is full.
    assign empty          = !vld_q[rd_q];
    assign bus.st_ready   = !vld_q[wr_q];
    assign accept         = bus.st_valid && bus.st_ready;
    assign push           = accept && !bad;
    assign pop            = !empty && bus.dready;
    assign bus.dvalid     = !empty;
    assign bus.sb_empty   = empty;
    assign bus.st_misalign = mis_q;
    assign bus.daddr      = empty ? 32'd0 : {addr_q[rd_q], 2'b00};
    assign bus.dwe        = empty ? 4'd0 : we_q[rd_q];
    assign bus.dwdata     = empty ? 32'd0 : data_q[rd_q];
    assign bus.ld_hazard  = haz;
    always_comb begin
        we_d = bus.st_size == 3'b000 ? 4'b0001 << bus.st_addr[1:0] :
               bus.st_size == 3'b001 ? (bus.st_addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
        data_d = bus.st_size == 3'b000 ? {4{bus.st_data[7:0]}} :
                 bus.st_size == 3'b001 ? {2{bus.st_data[15:0]}} : bus.st_data;
        bad = bus.st_size == 3'b000 ? 1'b0 :
              bus.st_size == 3'b001 ? bus.st_addr[0] :
              bus.st_size == 3'b010 ? |bus.st_addr[1:0] : 1'b1;
        haz = 1'b0;
        for (int i = 0; i < DEPTH; i++)
            haz = haz | (vld_q[i] && addr_q[i] == bus.ld_addr[31:2]);
    end
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            vld_q <= '0;
            rd_q  <= '0;
            wr_q  <= '0;
            mis_q <= 1'b0;
        end else begin
            mis_q <= accept && bad;
            if (pop) begin
                vld_q[rd_q] <= 1'b0;
                rd_q        <= rd_q + 1'b1;
            end
            if (push) begin
                vld_q[wr_q] <= 1'b1;
                wr_q        <= wr_q + 1'b1;
            end
        end
    end
    always_ff @(posedge clk_i) begin
        if (push) begin
            addr_q[wr_q] <= bus.st_addr[31:2];
            we_q[wr_q]   <= we_d;
            data_q[wr_q] <= data_d;
        end
    end
endmodule

// File: tb/tb_store_datagen.sv
// tb_store_datagen: directed and random store traffic checked against a queue-based reference model.
module tb_store_datagen;
    localparam int DEPTH = 2;
    typedef struct {
        logic [31:0] a;
        logic [3:0]  w;
        logic [31:0] d;
    } ent_t;
    logic clk, reset;
    int   checks, errors;
    logic exp_mis;
    ent_t q[$];
    store_datagen_if bus ();
    store_datagen #(.DEPTH(DEPTH)) dut (.clk_i(clk), .reset_i(reset), .bus(bus));
    initial clk = 1'b0;
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask
    task automatic drv(input logic v, input logic [2:0] sz, input logic [31:0] a,
                       input logic [31:0] d, input logic dr, input logic [31:0] ld);
        bus.st_valid = v;
        bus.st_size  = sz;
        bus.st_addr  = a;
        bus.st_data  = d;
        bus.dready   = dr;
        bus.ld_addr  = ld;
    endtask
    // Check outputs against the model, then advance the model across one clock edge.
    task automatic step();
        int   nb;
        logic acc, bad, pop, haz;
        ent_t e;
        #1;
        haz = 1'b0;
        foreach (q[i]) if (q[i].a[31:2] == bus.ld_addr[31:2]) haz = 1'b1;
        chk("dvalid", bus.dvalid, q.size() != 0);
        chk("daddr", bus.daddr, q.size() != 0 ? q[0].a : 32'd0);
        chk("dwe", bus.dwe, q.size() != 0 ? q[0].w : 4'd0);
        chk("dwdata", bus.dwdata, q.size() != 0 ? q[0].d : 32'd0);
        chk("st_ready", bus.st_ready, q.size() < DEPTH);
        chk("sb_empty", bus.sb_empty, q.size() == 0);
        chk("ld_hazard", bus.ld_hazard, haz);
        chk("st_misalign", bus.st_misalign, exp_mis);
        nb  = bus.st_size <= 3'd2 ? 1 << bus.st_size : 0;
        bad = nb == 0 || (bus.st_addr % nb) != 0;
        acc = bus.st_valid && q.size() < DEPTH;
        pop = q.size() != 0 && bus.dready;
        e.a = {bus.st_addr[31:2], 2'b00};
        e.w = 4'(((1 << nb) - 1) << bus.st_addr[1:0]);
        e.d = '0;
        if (nb != 0)
            for (int b = 0; b < 4; b++) e.d[8*b +: 8] = bus.st_data[8*(b % nb) +: 8];
        @(posedge clk);
        if (pop) void'(q.pop_front());
        if (acc && !bad) q.push_back(e);
        exp_mis = acc && bad;
        #1;
    endtask
    initial begin
        checks  = 0;
        errors  = 0;
        exp_mis = 1'b0;
        reset   = 1'b1;
        drv(0, 3'd0, 32'd0, 32'd0, 1'b1, 32'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        step();
        // SB at byte 3
        drv(1, 3'b000, 32'h103, 32'h000000AB, 1'b1, 32'd0);
        step();
        chk("sb_daddr", bus.daddr, 32'h100);
        chk("sb_dwe", bus.dwe, 4'b1000);
        chk("sb_dwdata", bus.dwdata, 32'hABABABAB);
        drv(0, 3'b000, 32'd0, 32'd0, 1'b1, 32'd0);
        step();
        chk("sb_popped", bus.sb_empty, 1'b1);
        // SH upper half then SW
        drv(1, 3'b001, 32'h202, 32'h00001234, 1'b1, 32'd0);
        step();
        chk("sh_dwe", bus.dwe, 4'b1100);
        chk("sh_dwdata", bus.dwdata, 32'h12341234);
        drv(1, 3'b010, 32'h300, 32'hDEADBEEF, 1'b1, 32'd0);
        step();
        chk("sw_dwe", bus.dwe, 4'b1111);
        chk("sw_dwdata", bus.dwdata, 32'hDEADBEEF);
        drv(0, 3'b000, 32'd0, 32'd0, 1'b1, 32'd0);
        step();
        // Fill with dready low, third request must stall
        drv(1, 3'b010, 32'h340, 32'h11111111, 1'b0, 32'd0);
        step();
        drv(1, 3'b000, 32'h345, 32'h00000022, 1'b0, 32'd0);
        step();
        drv(1, 3'b010, 32'h350, 32'h33333333, 1'b0, 32'd0);
        step();
        chk("full_ready", bus.st_ready, 1'b0);
        drv(0, 3'b000, 32'd0, 32'd0, 1'b1, 32'd0);
        step();
        step();
        chk("drain_empty", bus.sb_empty, 1'b1);
        // Misaligned SW and illegal size
        drv(1, 3'b010, 32'h401, 32'h55555555, 1'b1, 32'd0);
        step();
        chk("mis_pulse", bus.st_misalign, 1'b1);
        chk("mis_dvalid", bus.dvalid, 1'b0);
        drv(1, 3'b011, 32'h400, 32'h66666666, 1'b1, 32'd0);
        step();
        chk("ill_pulse", bus.st_misalign, 1'b1);
        drv(0, 3'b000, 32'd0, 32'd0, 1'b1, 32'd0);
        step();
        chk("mis_end", bus.st_misalign, 1'b0);
        // Load hazard against a buffered SW
        drv(1, 3'b010, 32'h500, 32'h77777777, 1'b0, 32'd0);
        step();
        drv(0, 3'b000, 32'd0, 32'd0, 1'b0, 32'h503);
        #1 chk("haz_same_word", bus.ld_hazard, 1'b1);
        bus.ld_addr = 32'h504;
        #1 chk("haz_next_word", bus.ld_hazard, 1'b0);
        step();
        // Reset with two buffered entries
        drv(1, 3'b010, 32'h510, 32'h88888888, 1'b0, 32'd0);
        step();
        chk("pre_reset_full", bus.st_ready, 1'b0);
        drv(0, 3'b000, 32'd0, 32'd0, 1'b0, 32'd0);
        reset = 1'b1;
        #1;
        chk("rst_dvalid", bus.dvalid, 1'b0);
        chk("rst_dwe", bus.dwe, 4'd0);
        chk("rst_empty", bus.sb_empty, 1'b1);
        q.delete();
        exp_mis = 1'b0;
        @(posedge clk);
        #1 reset = 1'b0;
        bus.dready = 1'b1;
        repeat (3) step();
        // Random traffic
        for (int n = 0; n < 400; n++) begin
            drv($urandom % 2 == 0,
                $urandom % 8 < 6 ? 3'($urandom % 3) : 3'(3 + $urandom % 5),
                32'h600 + 32'(($urandom % 4) * 4) + 32'($urandom % 4),
                $urandom,
                $urandom % 3 != 0,
                32'h600 + 32'(($urandom % 5) * 4) + 32'($urandom % 4));
            step();
        end
        drv(0, 3'b000, 32'd0, 32'd0, 1'b1, 32'd0);
        repeat (3) step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
